gen_m_nch: RTL
==============

Name: gen_m_nch

Overview:
- Multi-channel programmable pulse generator paced by a slow tick strobe (e.g. ce5ms).
- Each channel produces a pulse train: period x ticks, high time h ticks.
- Modes per channel: continuous or one-shot, with start/stop control and done/busy status.
- Sits between the tick divider and output drivers (LED/buzzer/servo lines); it is the parametrised successor of the single-channel x-driven generator.

Parameters:
CH, 4, number of independent channels
W, 11, width of period and high-time fields (ticks)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
ce  in  1  tick strobe, one clk wide; all timing counts in ticks
x  in  CH*W  per-channel period in ticks, channel i at [i*W +: W]
h  in  CH*W  per-channel high time in ticks, same packing
mode  in  CH  per-channel: 0 = continuous, 1 = one-shot
start  in  CH  per-channel start/restart request, level sampled each clk
stop  in  CH  per-channel abort request
s  out  CH  pulse outputs, registered
busy  out  CH  1 while channel in RUN
done  out  CH  one-clk pulse when a one-shot period completes

Behaviour:
- One clock. Reset is synchronous and active-low, with ports named clk and rst_n. On rst_n=0, all channels go to IDLE and cnt=0. s, busy and done are all 0 on the next edge, even when ce or start are active in the same cycle.
- Per-channel FSM states are IDLE and RUN. Internal registers: cnt[W-1:0], xl[W-1:0], hl[W-1:0] (latched period and high time).
- Priority per channel per clk: reset > stop > start > ce.
- IDLE with start=1 and x!=0: go to RUN, set cnt=0, and latch xl=x and hl=h.
- IDLE with start=1 and x==0: the request is ignored and the channel stays IDLE.
- RUN with stop=1: go to IDLE next edge with s=0 and no done pulse.
- RUN with start=1 (no stop): restart. Set cnt=0 and re-latch xl and hl. A ce in the same cycle is consumed by the restart and is not counted.
- RUN with ce=1 and cnt!=xl-1: cnt increments by 1.
- RUN with ce=1 and cnt==xl-1, i.e. period wrap:
  - Continuous mode: cnt=0 and re-latch xl=x and hl=h, so new settings take effect only at a period boundary. If the new x==0, go to IDLE with no done pulse.
  - One-shot mode: go to IDLE and pulse done=1 for exactly one clk.
- The entering ce is not counted. The first ce after entry to RUN moves cnt 0->1, so one period spans exactly xl ce strobes.
- s is registered and computed from the next-state values: s = (next state RUN) and (next cnt < next hl). As a result, s rises on the same edge that enters RUN when h>0.
- Boundary cases for h:
  - h=0: s stays 0 for the whole run.
  - h>=x: s is constant 1 while in RUN.
  - x=1: every ce is a wrap.
- busy = (state==RUN), registered alongside s.
- mode is sampled at the wrap, not latched at start.
- No arithmetic overflow: cnt never exceeds xl-1 and all compares are W-bit unsigned.
- Channels are fully independent; there is no shared state beyond ce.

Decomposition:
- Package gen_m_pkg contains:
  - state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1;
  - mode constants MODE_CONT=1'b0 and MODE_ONE=1'b1;
  - default CH and W.
- Sub-module gen_m_chan (single channel: FSM, cnt, xl, hl, s, busy, done; parameter W). The top is a generate loop over CH instances that slices x and h.

Test Plan:
- Bench config: CH=2, W=11, ce every 4 clk (scaled from 5 ms).
- Reset with start=2'b11 held and rst_n=0 for 3 clk -> s=busy=done=0 throughout; no channel enters RUN.
- ch0 continuous, x=4, h=1, start pulse -> s0 pattern per tick 1,0,0,0 repeating; busy0=1; period = 4 ce (16 clk); done0 never asserts.
- ch1 one-shot, x=5, h=3, start pulse -> s1 high for 3 ticks then low for 2; one done1 pulse on the 5th ce; busy1=0 afterwards; s1=0.
- ch0 continuous x=4 h=2: change x to 6 at mid-period -> current period still 4 ticks; the next period is 6 ticks with 2 high.
- Stop and start asserted in the same clk during RUN -> IDLE next edge, s=0, no done. Start with x=0 -> ignored, busy stays 0.
- Boundary h: h=0 -> s stays 0 for the whole run; h=7 with x=4 -> s constant 1 while busy. Restart mid-period in the same clk as ce -> cnt=0 and that tick is not counted (next period is a full 4 ce).

Source files
------------

// File: rtl/gen_m_pkg.sv
// Shared constants for the multi-channel pulse generator.
package gen_m_pkg;

  // Per-channel FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Channel mode select.
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_ONE  = 1'b1;

  // Default geometry.
  localparam int CH_DEF = 4;
  localparam int W_DEF  = 11;

endpackage

// File: rtl/gen_m_chan.sv
// Single pulse-generator channel: period/high-time counter paced by ce.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | stopped; s=0, waits for start with a non-zero period
// ST_RUN  | counting ticks 0..xl-1; s high while cnt < hl
module gen_m_chan
  import gen_m_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] x,
  input  logic [W-1:0] h,
  input  logic         mode,
  input  logic         start,
  input  logic         stop,
  output logic         s,
  output logic         busy,
  output logic         done
);

  state_t       st, st_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] xl, xl_n;
  logic [W-1:0] hl, hl_n;
  logic         done_n;
  logic         wrap;

  // xl is never zero in RUN, so xl-1 cannot underflow where it matters.
  assign wrap = (cnt == xl - 1'b1);

  // Next-state logic: stop beats start, start beats ce.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    xl_n   = xl;
    hl_n   = hl;
    done_n = 1'b0;
    case (st)
      ST_IDLE: begin
        if (!stop && start && (x != '0)) begin
          st_n  = ST_RUN;
          cnt_n = '0;
          xl_n  = x;
          hl_n  = h;
        end
      end
      ST_RUN: begin
        if (stop) begin
          st_n  = ST_IDLE;
          cnt_n = '0;
        end else if (start) begin
          // Restart swallows a coincident ce; a zero period cannot run.
          cnt_n = '0;
          xl_n  = x;
          hl_n  = h;
          if (x == '0) st_n = ST_IDLE;
        end else if (ce) begin
          if (!wrap) begin
            cnt_n = cnt + 1'b1;
          end else if (mode == MODE_CONT) begin
            // New settings only take effect at a period boundary.
            cnt_n = '0;
            xl_n  = x;
            hl_n  = h;
            if (x == '0) st_n = ST_IDLE;
          end else begin
            st_n   = ST_IDLE;
            cnt_n  = '0;
            done_n = 1'b1;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // State and registered outputs, derived from next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      xl   <= '0;
      hl   <= '0;
      s    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      xl   <= xl_n;
      hl   <= hl_n;
      s    <= (st_n == ST_RUN) && (cnt_n < hl_n);
      busy <= (st_n == ST_RUN);
      done <= done_n;
    end
  end

endmodule

// File: rtl/gen_m_nch.sv
// Multi-channel programmable pulse generator: CH independent channels.
module gen_m_nch
  import gen_m_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int W  = W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [CH*W-1:0] x,
  input  logic [CH*W-1:0] h,
  input  logic [CH-1:0] mode,
  input  logic [CH-1:0] start,
  input  logic [CH-1:0] stop,
  output logic [CH-1:0] s,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] done
);

  // One channel per bit; x and h are packed W bits per channel.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    gen_m_chan #(.W(W)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .x     (x[i*W +: W]),
      .h     (h[i*W +: W]),
      .mode  (mode[i]),
      .start (start[i]),
      .stop  (stop[i]),
      .s     (s[i]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end

endmodule
